// File: rtl/rv_pkg.sv
// Opcode and func3 constants shared by the RV32 encoder and decoder,
// plus the decoded-field bundle handed to the packer.
package rv_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [20:0] imm;
        logic        size;
    } enc_fields_t;

    // Load/store width select, as the decoder expects it back.
    function automatic logic [2:0] ls_func3(input logic size);
        return size ? F3_WORD : F3_BYTE;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packing for the supported RV32 formats.
// Flags any opcode outside the supported set.
module instr_pack
    import rv_pkg::*;
(
    input  enc_fields_t i_f,
    output logic [31:0] o_instr,
    output logic        o_illegal
);

    logic [2:0] w_f3_ls;
    logic       w_unused;

    assign w_f3_ls  = ls_func3(i_f.size);
    assign w_unused = i_f.imm[20];

    always_comb begin
        o_instr   = '0;
        o_illegal = 1'b0;
        unique case (i_f.opcode)
            OP_R: begin
                o_instr = {i_f.func7, i_f.r2, i_f.r1,
                           i_f.func3, i_f.rd, i_f.opcode};
            end
            OP_I, OP_JALR: begin
                o_instr = {i_f.imm[11:0], i_f.r1,
                           i_f.func3, i_f.rd, i_f.opcode};
            end
            OP_L: begin
                o_instr = {i_f.imm[11:0], i_f.r1,
                           w_f3_ls, i_f.rd, i_f.opcode};
            end
            OP_S: begin
                o_instr = {i_f.imm[11:5], i_f.r2, i_f.r1,
                           w_f3_ls, i_f.imm[4:0], i_f.opcode};
            end
            // imm carries offset/2, so bit 0 of the offset is implicit
            OP_B: begin
                o_instr = {i_f.imm[11], i_f.imm[9:4],
                           i_f.r2, i_f.r1, i_f.func3,
                           i_f.imm[3:0], i_f.imm[10],
                           i_f.opcode};
            end
            OP_JAL: begin
                o_instr = {i_f.imm[19], i_f.imm[9:0],
                           i_f.imm[10], i_f.imm[18:11],
                           i_f.rd, i_f.opcode};
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Pipelined RV32 encoder: packs decoded fields into instruction words
// and streams them to instruction memory at auto-incrementing addresses.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [4:0]        rd,
    input  logic [4:0]        r1,
    input  logic [4:0]        r2,
    input  logic [20:0]       imm,
    input  logic              size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    enc_fields_t       w_fields;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_accept;
    logic              w_fire;

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    assign w_fields = '{opcode: opcode, func3: func3, func7: func7,
                        rd: rd, r1: r1, r2: r2, imm: imm, size: size};

    instr_pack u_pack (
        .i_f       (w_fields),
        .o_instr   (w_word),
        .o_illegal (w_illegal)
    );

    // rst_n gates ready so no beat is taken while reset is held.
    assign in_ready = rst_n && !clear && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_fire   = r_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= BASE;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
            r_addr  <= BASE;
            r_err   <= 1'b0;
        end else begin
            if (w_fire) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_accept) begin
                // Illegal beats are swallowed; any drained word is gone.
                if (w_illegal) begin
                    r_err   <= 1'b1;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= 1'b1;
                    r_instr <= w_word;
                end
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_addr  = r_addr;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, backpressure,
// illegal opcodes, clear priority and address wrap.
module tb_instr_encoder;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [20:0] imm;
        logic        sz;
        logic [31:0] exp;
        logic        legal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready2 = 1'b1;
    logic        clear2 = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  func7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  r1 = '0;
    logic [4:0]  r2 = '0;
    logic [20:0] imm = '0;
    logic        size = 1'b0;

    logic        in_ready, out_valid, err;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        in_ready2, out_valid2, err2;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rd(rd), .r1(r1), .r2(r2), .imm(imm), .size(size),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rd(rd), .r1(r1), .r2(r2), .imm(imm), .size(size),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_addr(out_addr2), .err(err2)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        opcode = v.op;
        func3  = v.f3;
        func7  = v.f7;
        rd     = v.rd;
        r1     = v.r1;
        r2     = v.r2;
        imm    = v.imm;
        size   = v.sz;
    endtask

    vec_t vecs[9];
    logic [7:0]  exp_addr;
    logic [31:0] dec;

    initial begin
        vecs[0] = '{"R",    7'b0110011, 3'd0, 7'd0,    5'd3,  5'd1, 5'd2,
                    21'h1ABCD, 1'b1, 32'h002081B3, 1'b1};
        vecs[1] = '{"I",    7'b0010011, 3'd0, 7'h55,   5'd5,  5'd0, 5'd7,
                    21'd10,    1'b0, 32'h00A00293, 1'b1};
        vecs[2] = '{"S_w",  7'b0100011, 3'd7, 7'd0,    5'd31, 5'd1, 5'd2,
                    21'd8,     1'b1, 32'h0020A423, 1'b1};
        vecs[3] = '{"S_b",  7'b0100011, 3'd7, 7'd0,    5'd31, 5'd1, 5'd2,
                    21'd8,     1'b0, 32'h00208423, 1'b1};
        vecs[4] = '{"B",    7'b1100011, 3'd0, 7'd0,    5'd9,  5'd1, 5'd2,
                    21'h000FFC, 1'b0, 32'hFE208CE3, 1'b1};
        vecs[5] = '{"JAL",  7'b1101111, 3'd5, 7'd0,    5'd0,  5'd3, 5'd4,
                    21'd4,     1'b0, 32'h0080006F, 1'b1};
        vecs[6] = '{"ILL",  7'b1111111, 3'd0, 7'd0,    5'd1,  5'd1, 5'd1,
                    21'd0,     1'b0, 32'h0,        1'b0};
        vecs[7] = '{"L_w",  7'b0000011, 3'd0, 7'd0,    5'd6,  5'd2, 5'd0,
                    21'h0007FF, 1'b1, 32'h7FF12303, 1'b1};
        vecs[8] = '{"JALR", 7'b1100111, 3'd0, 7'd0,    5'd1,  5'd5, 5'd0,
                    21'h1FFFFF, 1'b0, 32'hFFF280E7, 1'b1};

        // Reset state
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", {24'b0, out_addr}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_out_valid", {31'b0, out_valid}, 32'd0);
        check("clr_out_addr", {24'b0, out_addr}, 32'd0);
        check("clr_err", {31'b0, err}, 32'd0);

        // Back-to-back vector stream with out_ready high
        exp_addr  = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            in_valid = 1'b1;
            #1;
            check({vecs[i].name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (vecs[i].legal) begin
                check({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'd1);
                check({vecs[i].name, "_instr"}, out_instr, vecs[i].exp);
                check({vecs[i].name, "_addr"}, {24'b0, out_addr},
                      {24'b0, exp_addr});
                exp_addr = exp_addr + 8'd1;
            end else begin
                check({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'd0);
                check({vecs[i].name, "_err"}, {31'b0, err}, 32'd1);
            end
            if (vecs[i].op == 7'b1100011) begin
                dec = {12'b0, out_instr[19:15], out_instr[24:20],
                       out_instr[14:12], out_instr[31], out_instr[7],
                       out_instr[30:25], out_instr[11:8]};
                check("B_roundtrip", dec,
                      {12'b0, vecs[i].r1, vecs[i].r2, vecs[i].f3,
                       vecs[i].imm[11:0]});
            end
            if (vecs[i].op == 7'b1101111) begin
                dec = {7'b0, out_instr[11:7], out_instr[31],
                       out_instr[19:12], out_instr[20], out_instr[30:21]};
                check("JAL_roundtrip", dec,
                      {7'b0, vecs[i].rd, vecs[i].imm[19:0]});
            end
        end
        @(posedge clk); #1;
        check("drain_valid", {31'b0, out_valid}, 32'd0);
        check("drain_addr", {24'b0, out_addr}, 32'd8);
        check("err_sticky", {31'b0, err}, 32'd1);

        // clear beats a simultaneous illegal beat
        @(negedge clk);
        apply(vecs[6]);
        clear    = 1'b1;
        in_valid = 1'b1;
        #1;
        check("clr_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr2_err", {31'b0, err}, 32'd0);
        check("clr2_addr", {24'b0, out_addr}, 32'd0);
        check("clr2_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: A held for two cycles, then B and C stream
        @(negedge clk);
        out_ready = 1'b0;
        apply(vecs[1]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_A_instr", out_instr, vecs[1].exp);
        check("bp_A_addr", {24'b0, out_addr}, 32'd0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            apply(vecs[7]);
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_instr", out_instr, vecs[1].exp);
            check("bp_hold_addr", {24'b0, out_addr}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_B_instr", out_instr, vecs[7].exp);
        check("bp_B_addr", {24'b0, out_addr}, 32'd1);
        @(negedge clk);
        apply(vecs[8]);
        @(posedge clk); #1;
        check("bp_C_instr", out_instr, vecs[8].exp);
        check("bp_C_addr", {24'b0, out_addr}, 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_end_valid", {31'b0, out_valid}, 32'd0);
        check("bp_end_addr", {24'b0, out_addr}, 32'd3);

        // ADDR_W=2 instance: fifth word wraps to address 0
        @(negedge clk);
        apply(vecs[0]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            @(posedge clk); #1;
            check("wrap_valid", {31'b0, out_valid2}, 32'd1);
            check("wrap_addr", {30'b0, out_addr2}, k % 4);
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        check("wrap_end_addr", {30'b0, out_addr2}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
